tmp101_reading_assembler: RTL and testbench
===========================================

Name: tmp101_reading_assembler

Overview:
- Downstream consumer of the I2C data unit's received-byte path during a TMP101 temperature read.
- Collects the two bytes of each read frame (MSB, then LSB) and forms the 12-bit two's-complement reading.
- Converts the reading to sign / integer degrees C / sixteenths of a degree, and presents the result with a one-cycle valid strobe to the display/readout logic.
- Counts completed samples and flags short (truncated) frames.

Parameters:
- RAW_W, 12, TMP101 result width in bits; 0.0625 C per LSB.
- COUNT_W, 8, width of the SampleCount wrap-around counter.

Ports:
- clock  input  1  system clock; all state changes on its rising edge.
- Reset  input  1  asynchronous, active-low reset.
- FrameStart  input  1  one-cycle pulse at the I2C start of a read frame.
- FrameAbort  input  1  one-cycle pulse at stop/NACK (end of frame).
- ByteValid  input  1  one-cycle pulse: ReceivedData holds a complete received byte.
- ReceivedData  input  8  byte from the I2C data unit.
- TempValid  output  1  one-cycle pulse: Temp* outputs were just updated.
- TempRaw  output  RAW_W  reading, {MSB, LSB[7:4]}.
- TempSign  output  1  1 = negative.
- TempInteger  output  8  magnitude, whole degrees C (0..128).
- TempFraction  output  4  magnitude fraction, in 1/16 C.
- SampleCount  output  COUNT_W  completed conversions, modulo 2^COUNT_W.
- ShortFrame  output  1  one-cycle pulse: frame ended after the MSB and before the LSB.
- Busy  output  1  high in WAIT_MSB, WAIT_LSB, CONVERT.

Behaviour:
- Reset (Reset=0, async): state IDLE; all outputs 0; MSB/LSB holding registers 0.
- States: IDLE, WAIT_MSB, WAIT_LSB, CONVERT.
- IDLE:
  - FrameStart -> WAIT_MSB.
  - ByteValid and FrameAbort are ignored.
- WAIT_MSB:
  - ByteValid -> capture MSB, go to WAIT_LSB.
  - FrameAbort -> IDLE, no ShortFrame.
  - FrameStart -> stay in WAIT_MSB.
- WAIT_LSB:
  - ByteValid -> capture LSB, go to CONVERT.
  - FrameAbort without ByteValid -> IDLE, ShortFrame=1 for one cycle.
  - FrameStart -> discard MSB, go to WAIT_MSB, ShortFrame=1.
- CONVERT (exactly one cycle):
  - Register all Temp* outputs, TempValid=1 on the following cycle, SampleCount+1 (255 wraps to 0).
  - Next state is IDLE, or WAIT_MSB if FrameStart is present this cycle.
  - ByteValid is ignored.
- Latency: LSB sampled at edge k; outputs and TempValid change at edge k+1; TempValid is high for exactly one cycle.
- Between strobes, Temp* outputs hold their last value.
- Simultaneous events:
  - FrameStart + ByteValid: FrameStart wins and the byte is dropped.
  - FrameAbort + ByteValid in WAIT_LSB: the byte is accepted and the conversion completes (normal stop after the last byte).
  - FrameAbort + ByteValid in WAIT_MSB: the byte is dropped; go to IDLE.
- Arithmetic:
  - raw = {MSB, LSB[7:4]}; LSB[3:0] is discarded.
  - TempSign = raw[11].
  - mag = TempSign ? (~raw + 1) : raw, held as 12-bit unsigned; 0x800 gives 2048.
  - TempInteger = mag[11:4] (8 bits).
  - TempFraction = mag[3:0].
- Reset mid-frame: the frame is abandoned immediately; no TempValid and no ShortFrame.

Optional Feature:
- Macro TMP101_AVERAGE_EN.
- When defined:
  - Keep a 4-entry history of raw values.
  - Conversion uses avg = (sum of the 4 newest raw values, 14-bit signed) >>> 2, i.e. floor.
  - The first conversion after reset preloads all 4 entries with the new sample.
  - Latency is unchanged; TempRaw reports the averaged value.
- When undefined: no history registers; the direct sample is reported.

Decomposition:
- Package tmp101_pkg holds:
  - the state enum (IDLE, WAIT_MSB, WAIT_LSB, CONVERT);
  - RAW_W, FRAC_W=4, INT_W=8, AVG_DEPTH=4.
- Sub-module tmp101_raw_to_celsius: combinational raw -> {sign, integer, fraction}, instantiated once in CONVERT.

Test Plan:
- FrameStart, MSB 0x19, LSB 0x10 -> TempRaw 0x191, Sign 0, Integer 25, Fraction 1; TempValid one cycle after LSB edge; SampleCount 1.
- MSB 0xE6, LSB 0xF0 -> raw 0xE6F, Sign 1, Integer 25, Fraction 1.
- Range limits:
  - MSB 0x7F, LSB 0xF0 -> Integer 127, Fraction 15.
  - MSB 0xC9, LSB 0x00 -> raw 0xC90, Sign 1, Integer 55, Fraction 0.
- FrameStart, MSB 0x19, then FrameAbort -> ShortFrame pulse, no TempValid, state IDLE.
- FrameStart, MSB, then FrameStart again with ByteValid in the same cycle -> ShortFrame, byte dropped; the next two bytes form the reading.
- Saturation and wrap:
  - 256 frames -> SampleCount wraps to 0.
  - Reset asserted in WAIT_LSB -> all outputs 0 immediately.
- With TMP101_AVERAGE_EN, frames 0x19/0x00 then 0x1A/0x00:
  - first frame -> Integer 25, Fraction 0;
  - second frame -> raw 0x194, Integer 25, Fraction 4.

Source files
------------

// File: rtl/tmp101_pkg.sv
// tmp101_pkg: shared types and constants for the TMP101 reading assembler.
// Optional build macro: TMP101_AVERAGE_EN (4-sample moving average).
package tmp101_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_MSB,
    WAIT_LSB,
    CONVERT
  } state_t;

  localparam int RAW_W     = 12;
  localparam int FRAC_W    = 4;
  localparam int INT_W     = 8;
  localparam int AVG_DEPTH = 4;

endpackage

// File: rtl/tmp101_raw_to_celsius.sv
// tmp101_raw_to_celsius: 12-bit two's-complement reading to
// sign / whole degrees / sixteenths of a degree (magnitude form).
module tmp101_raw_to_celsius
  import tmp101_pkg::*;
(
  input  logic [RAW_W-1:0]  raw,
  output logic              sign,
  output logic [INT_W-1:0]  whole,
  output logic [FRAC_W-1:0] frac
);

  logic [RAW_W-1:0] mag;

  // Magnitude: 0x800 negates to itself, read unsigned as 2048.
  always_comb begin
    sign  = raw[RAW_W-1];
    mag   = sign ? -raw : raw;
    whole = mag[RAW_W-1 -: INT_W];
    frac  = mag[FRAC_W-1:0];
  end

endmodule

// File: rtl/tmp101_reading_assembler.sv
// tmp101_reading_assembler: builds TMP101 readings from I2C read bytes.
// Optional build macro: TMP101_AVERAGE_EN (4-sample moving average).
module tmp101_reading_assembler #(
  parameter int RAW_W   = 12,
  parameter int COUNT_W = 8
) (
  input  logic               clock,
  input  logic               Reset,
  input  logic               FrameStart,
  input  logic               FrameAbort,
  input  logic               ByteValid,
  input  logic [7:0]         ReceivedData,
  output logic               TempValid,
  output logic [RAW_W-1:0]   TempRaw,
  output logic               TempSign,
  output logic [7:0]         TempInteger,
  output logic [3:0]         TempFraction,
  output logic [COUNT_W-1:0] SampleCount,
  output logic               ShortFrame,
  output logic               Busy
);
  import tmp101_pkg::*;

  state_t state;
  state_t next;

  logic       cap_msb;
  logic       cap_lsb;
  logic       short_nxt;
  logic [7:0] msb;
  logic [3:0] lsb_hi;

  logic [RAW_W-1:0]  sample;
  logic [RAW_W-1:0]  conv_raw;
  logic              conv_sign;
  logic [INT_W-1:0]  conv_int;
  logic [FRAC_W-1:0] conv_frac;

  assign sample = {msb, lsb_hi};
  assign Busy   = (state != IDLE);

  // State register.
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= next;
  end

  // Next state, byte capture strobes and short-frame detection.
  always_comb begin
    next      = state;
    cap_msb   = 1'b0;
    cap_lsb   = 1'b0;
    short_nxt = 1'b0;
    unique case (state)
      IDLE: begin
        if (FrameStart) next = WAIT_MSB;
      end
      WAIT_MSB: begin
        if (FrameStart) begin
          next = WAIT_MSB;
        end else if (FrameAbort) begin
          next = IDLE;
        end else if (ByteValid) begin
          cap_msb = 1'b1;
          next    = WAIT_LSB;
        end
      end
      WAIT_LSB: begin
        if (FrameStart) begin
          next      = WAIT_MSB;
          short_nxt = 1'b1;
        end else if (ByteValid) begin
          cap_lsb = 1'b1;
          next    = CONVERT;
        end else if (FrameAbort) begin
          next      = IDLE;
          short_nxt = 1'b1;
        end
      end
      CONVERT: begin
        next = FrameStart ? WAIT_MSB : IDLE;
      end
      default: next = IDLE;
    endcase
  end

  // Byte holding registers; LSB low nibble is never used.
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      msb    <= '0;
      lsb_hi <= '0;
    end else begin
      if (cap_msb) msb    <= ReceivedData;
      if (cap_lsb) lsb_hi <= ReceivedData[7:4];
    end
  end

`ifdef TMP101_AVERAGE_EN
  // Window = new sample plus the three most recent retained ones.
  logic [RAW_W-1:0]        hist [AVG_DEPTH-1];
  logic                    primed;
  logic signed [RAW_W+1:0] sum;

  // Sign-extended window sum; floor divide by four.
  always_comb begin
    sum = {{2{sample[RAW_W-1]}}, sample};
    for (int i = 0; i < AVG_DEPTH - 1; i++)
      sum = sum + {{2{hist[i][RAW_W-1]}}, hist[i]};
    conv_raw = primed ? RAW_W'(sum >>> 2) : sample;
  end

  // History shift; first conversion preloads every entry.
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      primed <= 1'b0;
      for (int i = 0; i < AVG_DEPTH - 1; i++) hist[i] <= '0;
    end else if (state == CONVERT) begin
      primed  <= 1'b1;
      hist[0] <= sample;
      for (int i = 1; i < AVG_DEPTH - 1; i++)
        hist[i] <= primed ? hist[i-1] : sample;
    end
  end
`else
  // Direct sample.
  always_comb conv_raw = sample;
`endif

  tmp101_raw_to_celsius u_conv (
    .raw   (conv_raw),
    .sign  (conv_sign),
    .whole (conv_int),
    .frac  (conv_frac)
  );

  // Result registers, strobes and sample counter.
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      TempValid    <= 1'b0;
      TempRaw      <= '0;
      TempSign     <= 1'b0;
      TempInteger  <= '0;
      TempFraction <= '0;
      SampleCount  <= '0;
      ShortFrame   <= 1'b0;
    end else begin
      TempValid  <= 1'b0;
      ShortFrame <= short_nxt;
      if (state == CONVERT) begin
        TempValid    <= 1'b1;
        TempRaw      <= conv_raw;
        TempSign     <= conv_sign;
        TempInteger  <= conv_int;
        TempFraction <= conv_frac;
        SampleCount  <= SampleCount + COUNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_tmp101_reading_assembler.sv
// tb_tmp101_reading_assembler: directed checks of the reading assembler.
// Define TMP101_AVERAGE_EN to exercise the averaging build instead.
module tb_tmp101_reading_assembler;

  logic        clock;
  logic        Reset;
  logic        FrameStart;
  logic        FrameAbort;
  logic        ByteValid;
  logic [7:0]  ReceivedData;
  logic        TempValid;
  logic [11:0] TempRaw;
  logic        TempSign;
  logic [7:0]  TempInteger;
  logic [3:0]  TempFraction;
  logic [7:0]  SampleCount;
  logic        ShortFrame;
  logic        Busy;

  int passed = 0;
  int total  = 0;
  int exp_count = 0;

  tmp101_reading_assembler #(.RAW_W(12), .COUNT_W(8)) dut (
    .clock        (clock),
    .Reset        (Reset),
    .FrameStart   (FrameStart),
    .FrameAbort   (FrameAbort),
    .ByteValid    (ByteValid),
    .ReceivedData (ReceivedData),
    .TempValid    (TempValid),
    .TempRaw      (TempRaw),
    .TempSign     (TempSign),
    .TempInteger  (TempInteger),
    .TempFraction (TempFraction),
    .SampleCount  (SampleCount),
    .ShortFrame   (ShortFrame),
    .Busy         (Busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Start + MSB + LSB; returns just after the LSB edge (in CONVERT).
  task automatic send_frame(input logic [7:0] m, input logic [7:0] l);
    FrameStart = 1'b1;
    cyc();
    FrameStart   = 1'b0;
    ByteValid    = 1'b1;
    ReceivedData = m;
    cyc();
    ReceivedData = l;
    cyc();
    ByteValid = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    repeat (2) cyc();
    total++;
    if ({TempValid, TempRaw, TempSign, TempInteger, TempFraction} !== 26'h0)
      $display("FAIL reset_temp got %h want 0",
               {TempValid, TempRaw, TempSign, TempInteger, TempFraction});
    else passed++;
    total++;
    if ({SampleCount, ShortFrame, Busy} !== 10'h0)
      $display("FAIL reset_misc got %h want 0", {SampleCount, ShortFrame, Busy});
    else passed++;
    Reset = 1'b1;
    cyc();
  endtask

  task automatic test_positive();
    send_frame(8'h19, 8'h10);
    total++;
    if (TempValid !== 1'b0)
      $display("FAIL pos_early_valid got %b want 0", TempValid);
    else passed++;
    cyc();
    exp_count++;
    total++;
    if (TempValid !== 1'b1) $display("FAIL pos_valid got %b want 1", TempValid);
    else passed++;
    total++;
    if (TempRaw !== 12'h191) $display("FAIL pos_raw got %h want 191", TempRaw);
    else passed++;
    total++;
    if ({TempSign, TempInteger, TempFraction} !== {1'b0, 8'd25, 4'd1})
      $display("FAIL pos_celsius got %h want %h",
               {TempSign, TempInteger, TempFraction}, {1'b0, 8'd25, 4'd1});
    else passed++;
    total++;
    if (SampleCount !== 8'd1) $display("FAIL pos_count got %0d want 1", SampleCount);
    else passed++;
    cyc();
    total++;
    if ({TempValid, Busy, TempRaw} !== {1'b0, 1'b0, 12'h191})
      $display("FAIL pos_after got %h want %h",
               {TempValid, Busy, TempRaw}, {1'b0, 1'b0, 12'h191});
    else passed++;
  endtask

  task automatic test_negative();
    send_frame(8'hE6, 8'hF0);
    cyc();
    exp_count++;
    total++;
    if ({TempValid, TempRaw} !== {1'b1, 12'hE6F})
      $display("FAIL neg_raw got %h want %h", {TempValid, TempRaw}, {1'b1, 12'hE6F});
    else passed++;
    total++;
    if ({TempSign, TempInteger, TempFraction} !== {1'b1, 8'd25, 4'd1})
      $display("FAIL neg_celsius got %h want %h",
               {TempSign, TempInteger, TempFraction}, {1'b1, 8'd25, 4'd1});
    else passed++;
  endtask

  task automatic test_limits();
    logic [7:0]  ms [3];
    logic [7:0]  ls [3];
    logic [11:0] rw [3];
    logic [12:0] cel [3];
    ms  = '{8'h7F, 8'hC9, 8'h80};
    ls  = '{8'hF0, 8'h00, 8'h0F};
    rw  = '{12'h7FF, 12'hC90, 12'h800};
    cel = '{{1'b0, 8'd127, 4'd15}, {1'b1, 8'd55, 4'd0}, {1'b1, 8'd128, 4'd0}};
    for (int i = 0; i < 3; i++) begin
      send_frame(ms[i], ls[i]);
      cyc();
      exp_count++;
      total++;
      if ({TempValid, TempRaw} !== {1'b1, rw[i]})
        $display("FAIL lim%0d_raw got %h want %h", i, {TempValid, TempRaw}, {1'b1, rw[i]});
      else passed++;
      total++;
      if ({TempSign, TempInteger, TempFraction} !== cel[i])
        $display("FAIL lim%0d_celsius got %h want %h", i,
                 {TempSign, TempInteger, TempFraction}, cel[i]);
      else passed++;
      total++;
      if (SampleCount !== 8'(exp_count))
        $display("FAIL lim%0d_count got %0d want %0d", i, SampleCount, exp_count);
      else passed++;
    end
    cyc();
  endtask

  task automatic test_short_abort();
    FrameStart = 1'b1;
    cyc();
    FrameStart   = 1'b0;
    ByteValid    = 1'b1;
    ReceivedData = 8'h19;
    cyc();
    ByteValid  = 1'b0;
    FrameAbort = 1'b1;
    cyc();
    FrameAbort = 1'b0;
    total++;
    if ({ShortFrame, TempValid, Busy} !== 3'b100)
      $display("FAIL short_pulse got %b want 100", {ShortFrame, TempValid, Busy});
    else passed++;
    cyc();
    total++;
    if ({ShortFrame, TempRaw} !== {1'b0, 12'h800})
      $display("FAIL short_hold got %h want %h", {ShortFrame, TempRaw}, {1'b0, 12'h800});
    else passed++;
    total++;
    if (SampleCount !== 8'(exp_count))
      $display("FAIL short_count got %0d want %0d", SampleCount, exp_count);
    else passed++;
    FrameStart = 1'b1;
    cyc();
    FrameStart = 1'b0;
    FrameAbort = 1'b1;
    ByteValid  = 1'b1;
    cyc();
    FrameAbort = 1'b0;
    ByteValid  = 1'b0;
    total++;
    if ({ShortFrame, Busy} !== 2'b00)
      $display("FAIL msb_abort got %b want 00", {ShortFrame, Busy});
    else passed++;
    cyc();
  endtask

  task automatic test_restart();
    FrameStart = 1'b1;
    cyc();
    FrameStart   = 1'b0;
    ByteValid    = 1'b1;
    ReceivedData = 8'h20;
    cyc();
    FrameStart   = 1'b1;
    ReceivedData = 8'h55;
    cyc();
    FrameStart = 1'b0;
    total++;
    if ({ShortFrame, Busy} !== 2'b11)
      $display("FAIL restart_short got %b want 11", {ShortFrame, Busy});
    else passed++;
    ReceivedData = 8'h32;
    cyc();
    ReceivedData = 8'h80;
    cyc();
    ByteValid = 1'b0;
    cyc();
    exp_count++;
    total++;
    if ({TempValid, TempRaw} !== {1'b1, 12'h328})
      $display("FAIL restart_raw got %h want %h", {TempValid, TempRaw}, {1'b1, 12'h328});
    else passed++;
    total++;
    if ({TempSign, TempInteger, TempFraction} !== {1'b0, 8'd50, 4'd8})
      $display("FAIL restart_celsius got %h want %h",
               {TempSign, TempInteger, TempFraction}, {1'b0, 8'd50, 4'd8});
    else passed++;
  endtask

  task automatic test_abort_with_lsb();
    FrameStart = 1'b1;
    cyc();
    FrameStart   = 1'b0;
    ByteValid    = 1'b1;
    ReceivedData = 8'h01;
    cyc();
    ReceivedData = 8'h20;
    FrameAbort   = 1'b1;
    cyc();
    ByteValid  = 1'b0;
    FrameAbort = 1'b0;
    total++;
    if ({ShortFrame, Busy} !== 2'b01)
      $display("FAIL stop_lsb_state got %b want 01", {ShortFrame, Busy});
    else passed++;
    cyc();
    exp_count++;
    total++;
    if ({TempValid, TempRaw, TempInteger, TempFraction} !== {1'b1, 12'h012, 8'd1, 4'd2})
      $display("FAIL stop_lsb_raw got %h want %h",
               {TempValid, TempRaw, TempInteger, TempFraction}, {1'b1, 12'h012, 8'd1, 4'd2});
    else passed++;
  endtask

  task automatic test_back_to_back();
    send_frame(8'h19, 8'h10);
    FrameStart = 1'b1;
    cyc();
    FrameStart = 1'b0;
    exp_count++;
    total++;
    if ({TempValid, Busy, TempRaw} !== {1'b1, 1'b1, 12'h191})
      $display("FAIL b2b_first got %h want %h",
               {TempValid, Busy, TempRaw}, {1'b1, 1'b1, 12'h191});
    else passed++;
    ByteValid    = 1'b1;
    ReceivedData = 8'h00;
    cyc();
    ReceivedData = 8'h50;
    cyc();
    ByteValid = 1'b0;
    cyc();
    exp_count++;
    total++;
    if ({TempValid, TempRaw, TempInteger, TempFraction} !== {1'b1, 12'h005, 8'd0, 4'd5})
      $display("FAIL b2b_second got %h want %h",
               {TempValid, TempRaw, TempInteger, TempFraction}, {1'b1, 12'h005, 8'd0, 4'd5});
    else passed++;
    total++;
    if (SampleCount !== 8'(exp_count))
      $display("FAIL b2b_count got %0d want %0d", SampleCount, exp_count);
    else passed++;
    cyc();
  endtask

  task automatic test_idle_ignored();
    ByteValid    = 1'b1;
    FrameAbort   = 1'b1;
    ReceivedData = 8'hFF;
    cyc();
    ByteValid  = 1'b0;
    FrameAbort = 1'b0;
    cyc();
    total++;
    if ({Busy, TempValid, ShortFrame, TempRaw} !== {3'b000, 12'h005})
      $display("FAIL idle_ignore got %h want %h",
               {Busy, TempValid, ShortFrame, TempRaw}, {3'b000, 12'h005});
    else passed++;
  endtask

  task automatic test_wrap();
    int n;
    n = 256 - (exp_count % 256);
    for (int i = 0; i < n; i++) begin
      send_frame(8'h10, 8'h00);
      cyc();
      exp_count++;
    end
    total++;
    if (SampleCount !== 8'h00)
      $display("FAIL wrap_count got %0d want 0", SampleCount);
    else passed++;
  endtask

  task automatic test_reset_mid();
    FrameStart = 1'b1;
    cyc();
    FrameStart   = 1'b0;
    ByteValid    = 1'b1;
    ReceivedData = 8'h19;
    cyc();
    ByteValid = 1'b0;
    total++;
    if (Busy !== 1'b1) $display("FAIL mid_busy got %b want 1", Busy);
    else passed++;
    Reset = 1'b0;
    #1;
    total++;
    if ({TempValid, TempRaw, TempSign, TempInteger, TempFraction,
         SampleCount, ShortFrame, Busy} !== 36'h0)
      $display("FAIL mid_reset got %h want 0",
               {TempValid, TempRaw, TempSign, TempInteger, TempFraction,
                SampleCount, ShortFrame, Busy});
    else passed++;
    cyc();
    Reset = 1'b1;
    cyc();
    cyc();
    total++;
    if ({TempValid, ShortFrame, Busy} !== 3'b000)
      $display("FAIL mid_after got %b want 000", {TempValid, ShortFrame, Busy});
    else passed++;
  endtask

  task automatic test_average();
    send_frame(8'h19, 8'h00);
    cyc();
    total++;
    if ({TempValid, TempRaw, TempInteger, TempFraction} !== {1'b1, 12'h190, 8'd25, 4'd0})
      $display("FAIL avg_first got %h want %h",
               {TempValid, TempRaw, TempInteger, TempFraction}, {1'b1, 12'h190, 8'd25, 4'd0});
    else passed++;
    send_frame(8'h1A, 8'h00);
    cyc();
    total++;
    if ({TempValid, TempRaw, TempInteger, TempFraction} !== {1'b1, 12'h194, 8'd25, 4'd4})
      $display("FAIL avg_second got %h want %h",
               {TempValid, TempRaw, TempInteger, TempFraction}, {1'b1, 12'h194, 8'd25, 4'd4});
    else passed++;
  endtask

  initial begin
    Reset        = 1'b0;
    FrameStart   = 1'b0;
    FrameAbort   = 1'b0;
    ByteValid    = 1'b0;
    ReceivedData = 8'h00;
    test_reset();
`ifdef TMP101_AVERAGE_EN
    test_average();
`else
    test_positive();
    test_negative();
    test_limits();
    test_short_abort();
    test_restart();
    test_abort_with_lsb();
    test_back_to_back();
    test_idle_ignored();
    test_wrap();
    test_reset_mid();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
